// File: rtl/lc3_fields_pkg.sv
// -----------------------------------------------------------------------------
// lc3_fields_pkg
// Shared definitions for the LC-3 immediate/offset fields. The sign-extenders
// use these to widen a field back to 16 bits. The offset encoder and the
// assembler lint logic use them to narrow a 16-bit value into a field.
//
// Contents:
//   field_sel_t      - which field is being handled (imm5/offset6/PC9/PC11)
//   field_width()    - bit width W of a field
//   low_mask()       - 16-bit mask covering bits [W-1:0]
//   fits_signed()    - does a 16-bit value survive narrowing to W signed bits
//   is_pc_relative() - field is an offset from the incremented PC
//   sign_extend()    - widen a W-bit field (held in 11 bits) to 16 bits
// -----------------------------------------------------------------------------
package lc3_fields_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned FIELD_MAX_W = 11;

  typedef enum logic [1:0] {
    FS_IMM5 = 2'b00,
    FS_OFF6 = 2'b01,
    FS_PC9  = 2'b10,
    FS_PC11 = 2'b11
  } field_sel_t;

  function automatic logic [3:0] field_width(input field_sel_t fs);
    logic [3:0] w;
    case (fs)
      FS_IMM5: w = 4'd5;
      FS_OFF6: w = 4'd6;
      FS_PC9:  w = 4'd9;
      FS_PC11: w = 4'd11;
      default: w = 4'd5;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] low_mask(input logic [3:0] w);
    logic [15:0] m;
    case (w)
      4'd5:    m = 16'h001F;
      4'd6:    m = 16'h003F;
      4'd9:    m = 16'h01FF;
      4'd11:   m = 16'h07FF;
      default: m = 16'h001F;
    endcase
    return m;
  endfunction

  // A value fits in W signed bits when bits [15:W-1] are all equal.
  // Shifting the low mask right by one leaves bits [W-2:0] set, so its
  // complement selects exactly bits [15:W-1].
  function automatic logic fits_signed(input logic [15:0] off, input logic [3:0] w);
    logic [15:0] hi;
    logic [15:0] upper;
    hi    = ~(low_mask(w) >> 1);
    upper = off & hi;
    return (upper == 16'h0000) || (upper == hi);
  endfunction

  function automatic logic is_pc_relative(input field_sel_t fs);
    logic r;
    case (fs)
      FS_PC9, FS_PC11: r = 1'b1;
      FS_IMM5, FS_OFF6: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // The sign bit is the top bit of the field: the mask XOR its own
  // right shift isolates that single bit position.
  function automatic logic [15:0] sign_extend(input logic [10:0] f, input logic [3:0] w);
    logic [15:0] m;
    logic [15:0] wide;
    logic        sb;
    m    = low_mask(w);
    wide = {5'b00000, f} & m;
    sb   = |(wide & (m ^ (m >> 1)));
    return sb ? (wide | ~m) : wide;
  endfunction

endpackage

// File: rtl/field_range_check.sv
// -----------------------------------------------------------------------------
// field_range_check
// Combinational narrowing of a 16-bit offset into an LC-3 field, with the
// check that the field sign-extends back to the same 16-bit value.
//
// Ports:
//   off   in  16  value to narrow
//   fsel  in   2  field select (field_sel_t encoding)
//   field out 11  low W bits of off, zero-extended to 11 bits
//   fit   out  1  1 when off is representable in W signed bits
// -----------------------------------------------------------------------------
module field_range_check
  import lc3_fields_pkg::*;
(
  input  logic [15:0] off,
  input  logic [1:0]  fsel,
  output logic [10:0] field,
  output logic        fit
);

  logic [3:0]  width_s;
  logic [15:0] mask_s;

  // Field extraction and range test for the selected width
  always_comb begin
    width_s = field_width(field_sel_t'(fsel));
    mask_s  = low_mask(width_s);
    // On a range error the truncated low bits are still what we deliver.
    field   = 11'(off & mask_s);
    fit     = fits_signed(off, width_s);
  end

endmodule

// File: rtl/offset_field_encoder.sv
// -----------------------------------------------------------------------------
// offset_field_encoder
// Packs a 16-bit value or branch/load target into an LC-3 immediate/offset
// field and merges it into an instruction template. It is a two-stage
// valid/ready pipeline with one result per cycle and two cycles of latency.
//
// Stage 1 registers the offset: the raw value for imm5/offset6, or
// target - (pc + 1) for PCoffset9/11. Stage 2 registers the merged
// instruction, the field and the range flag, so every output is a flop.
//
// Ports:
//   Clk        in   1   clock, all state on the rising edge
//   Reset      in   1   synchronous active-low reset
//   in_valid   in   1   request valid
//   in_ready   out  1   request can be accepted this cycle
//   fsel       in   2   00 imm5, 01 offset6, 10 PCoffset9, 11 PCoffset11
//   pc         in  16   address of the instruction (PC-relative fields only)
//   target     in  16   raw value or target address
//   base_ir    in  16   instruction template, low W bits replaced
//   out_valid  out  1   result valid
//   out_ready  in   1   consumer accepts result
//   ir_out     out 16   merged instruction
//   field_out  out 11   field, zero-extended
//   range_err  out  1   value does not fit in W signed bits
//   err_count  out ERR_CNT_W  saturating count of delivered range errors
// -----------------------------------------------------------------------------
module offset_field_encoder
  import lc3_fields_pkg::*;
#(
  parameter int ERR_CNT_W = 8
)
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           fsel,
  input  logic [15:0]          pc,
  input  logic [15:0]          target,
  input  logic [15:0]          base_ir,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          ir_out,
  output logic [10:0]          field_out,
  output logic                 range_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  // handshake qualifiers
  logic                 s2_adv_s;
  logic                 accept_s;
  logic                 deliver_s;

  // stage 1
  logic [15:0]          off_s;
  logic                 s1_valid_r;
  logic [15:0]          s1_off_r;
  field_sel_t           s1_fsel_r;
  logic [15:0]          s1_base_r;

  // stage 1 -> stage 2 combinational results
  logic [10:0]          chk_field_s;
  logic                 chk_fit_s;
  logic [15:0]          merge_mask_s;
  logic [15:0]          merge_ir_s;

  // stage 2
  logic                 s2_valid_r;
  logic [15:0]          s2_ir_r;
  logic [10:0]          s2_field_r;
  logic                 s2_err_r;
  logic [ERR_CNT_W-1:0] err_count_r;

  // Flow control: stage 2 frees up when empty or being drained; stage 1
  // can take a new request when empty or when it moves into stage 2.
  // in_ready depends only on state and out_ready, never on in_valid.
  always_comb begin
    s2_adv_s  = ~s2_valid_r | out_ready;
    in_ready  = ~s1_valid_r | s2_adv_s;
    accept_s  = in_valid & in_ready;
    deliver_s = s2_valid_r & out_ready;
  end

  // Offset relative to the incremented PC, wrapping mod 2^16
  always_comb begin
    if (is_pc_relative(field_sel_t'(fsel))) begin
      off_s = target - (pc + 16'd1);
    end else begin
      off_s = target;
    end
  end

  // Stage 1 register: load on accept, empty when contents move on
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      s1_valid_r <= 1'b0;
      s1_off_r   <= 16'h0000;
      s1_fsel_r  <= FS_IMM5;
      s1_base_r  <= 16'h0000;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_off_r   <= off_s;
      s1_fsel_r  <= field_sel_t'(fsel);
      s1_base_r  <= base_ir;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  field_range_check u_range_check (
    .off   (s1_off_r),
    .fsel  (s1_fsel_r),
    .field (chk_field_s),
    .fit   (chk_fit_s)
  );

  // Template merge: low W bits come from the offset, the rest from base_ir
  always_comb begin
    merge_mask_s = low_mask(field_width(s1_fsel_r));
    merge_ir_s   = (s1_base_r & ~merge_mask_s) | (s1_off_r & merge_mask_s);
  end

  // Stage 2 register: data only changes when a new result moves in, so
  // outputs hold while the consumer stalls
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      s2_valid_r <= 1'b0;
      s2_ir_r    <= 16'h0000;
      s2_field_r <= 11'h000;
      s2_err_r   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_ir_r    <= merge_ir_s;
        s2_field_r <= chk_field_s;
        s2_err_r   <= ~chk_fit_s;
      end
    end
  end

  // Saturating count of range errors actually handed to the consumer
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      err_count_r <= {ERR_CNT_W{1'b0}};
    end else if (deliver_s && s2_err_r && (err_count_r != ERR_CNT_MAX)) begin
      err_count_r <= err_count_r + ERR_CNT_ONE;
    end
  end

  assign out_valid = s2_valid_r;
  assign ir_out    = s2_ir_r;
  assign field_out = s2_field_r;
  assign range_err = s2_err_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_offset_field_encoder.sv
module tb_offset_field_encoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fsel;
  logic [15:0] pc;
  logic [15:0] target;
  logic [15:0] base_ir;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ir_out;
  logic [10:0] field_out;
  logic        range_err;
  logic [7:0]  err_count;

  offset_field_encoder #(.ERR_CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .fsel(fsel), .pc(pc), .target(target), .base_ir(base_ir),
    .out_valid(out_valid), .out_ready(out_ready), .ir_out(ir_out),
    .field_out(field_out), .range_err(range_err), .err_count(err_count)
  );

  always #5 Clk = ~Clk;

  int vecs = 0;
  int miss = 0;

  typedef struct {
    logic        present;
    logic [15:0] ir;
    logic [10:0] fld;
    logic        err;
  } exp_t;

  typedef struct {
    logic        acc;
    logic        dlv;
    logic        rdy;
    logic        ovld;
    logic        ordy;
    logic [15:0] ir;
    logic [10:0] fld;
    logic        err;
  } obs_t;

  exp_t q[$];
  int   ecnt = 0;

  // Reference: signed-range arithmetic on plain integers
  function automatic exp_t model(input logic [1:0] fs, input logic [15:0] p,
                                 input logic [15:0] t, input logic [15:0] b);
    exp_t r;
    int w, off, sv, span, fld, bi;
    w = (fs == 2'd0) ? 5 : (fs == 2'd1) ? 6 : (fs == 2'd2) ? 9 : 11;
    if (fs >= 2'd2) off = int'(t) - int'(p) - 1;
    else            off = int'(t);
    if (off < 0) off = off + 65536;
    sv   = (off >= 32768) ? off - 65536 : off;
    span = 1 << (w - 1);
    fld  = off % (2 * span);
    bi   = int'(b);
    r.present = 1'b1;
    r.err     = !((sv >= -span) && (sv < span));
    r.fld     = fld[10:0];
    r.ir      = 16'(bi - (bi % (2 * span)) + fld);
    return r;
  endfunction

  // One clock: observe at negedge, update model, return at posedge+1
  task automatic step(output obs_t o, output exp_t e);
    @(negedge Clk);
    o.acc  = in_valid && in_ready;
    o.dlv  = out_valid && out_ready;
    o.rdy  = in_ready;
    o.ovld = out_valid;
    o.ordy = out_ready;
    o.ir   = ir_out;
    o.fld  = field_out;
    o.err  = range_err;
    e.present = 1'b0;
    e.ir      = 16'h0000;
    e.fld     = 11'h000;
    e.err     = 1'b0;
    if (!Reset) begin
      q.delete();
      ecnt = 0;
    end else begin
      if (o.dlv && q.size() > 0) begin
        e = q.pop_front();
        if (e.err && ecnt < 255) ecnt++;
      end
      if (o.acc) q.push_back(model(fsel, pc, target, base_ir));
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o; exp_t e;
    Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fsel = 2'd0; pc = 16'h0000; target = 16'h0000; base_ir = 16'h0000;
    repeat (2) step(o, e);
    Reset = 1'b1;
    vecs++; if (out_valid !== 1'b0) begin miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin miss++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vecs++; if (err_count !== 8'd0) begin miss++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    vecs++; if ({ir_out, field_out, range_err} !== 28'h0) begin
      miss++; $display("FAIL reset_outputs ir=%h fld=%h err=%b want zeros", ir_out, field_out, range_err);
    end
  endtask

  task automatic test_directed();
    obs_t o; exp_t e;
    logic [1:0]  d_fs[5]  = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd3};
    logic [15:0] d_pc[5]  = '{16'h3000, 16'h3000, 16'h0000, 16'h0000, 16'hFFFF};
    logic [15:0] d_tg[5]  = '{16'h3005, 16'h2F00, 16'hFFF0, 16'h0010, 16'h0002};
    logic [15:0] d_bs[5]  = '{16'h0E00, 16'h0E00, 16'h1020, 16'h1020, 16'h4800};
    logic [15:0] d_ir[5]  = '{16'h0E04, 16'h0EFF, 16'h1030, 16'h1030, 16'h4802};
    logic [10:0] d_fd[5]  = '{11'h004, 11'h0FF, 11'h010, 11'h010, 11'h002};
    logic        d_er[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0]  d_cn[5]  = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
    for (int i = 0; i < 5; i++) begin
      fsel = d_fs[i]; pc = d_pc[i]; target = d_tg[i]; base_ir = d_bs[i];
      in_valid = 1'b1; out_ready = 1'b1;
      step(o, e);
      vecs++; if (o.acc !== 1'b1) begin miss++; $display("FAIL dir_accept[%0d] got %b want 1", i, o.acc); end
      in_valid = 1'b0;
      vecs++; if (out_valid !== 1'b0) begin miss++; $display("FAIL dir_latency1[%0d] out_valid got %b want 0", i, out_valid); end
      step(o, e);
      vecs++; if ({out_valid, ir_out, field_out, range_err} !== {1'b1, d_ir[i], d_fd[i], d_er[i]}) begin
        miss++; $display("FAIL dir_result[%0d] got v=%b ir=%h fld=%h err=%b want v=1 ir=%h fld=%h err=%b",
                         i, out_valid, ir_out, field_out, range_err, d_ir[i], d_fd[i], d_er[i]);
      end
      step(o, e);
      vecs++; if (o.dlv !== 1'b1 || err_count !== d_cn[i]) begin
        miss++; $display("FAIL dir_errcnt[%0d] dlv=%b cnt=%0d want dlv=1 cnt=%0d", i, o.dlv, err_count, d_cn[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    obs_t o; exp_t e;
    logic [1:0]  r_fs[3]; logic [15:0] r_pc[3]; logic [15:0] r_tg[3]; logic [15:0] r_bs[3];
    for (int i = 0; i < 3; i++) begin
      r_fs[i] = 2'($urandom); r_pc[i] = 16'($urandom); r_bs[i] = 16'($urandom);
      r_tg[i] = 16'(int'(r_pc[i]) + 1 + int'($urandom_range(0, 600)) - 300);
    end
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fsel = r_fs[i]; pc = r_pc[i]; target = r_tg[i]; base_ir = r_bs[i];
      step(o, e);
      vecs++; if (o.acc !== 1'b1) begin miss++; $display("FAIL bp_accept[%0d] got %b want 1", i, o.acc); end
    end
    fsel = r_fs[2]; pc = r_pc[2]; target = r_tg[2]; base_ir = r_bs[2];
    vecs++; if (in_ready !== 1'b0) begin miss++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    for (int c = 0; c < 4; c++) begin
      step(o, e);
      vecs++; if (o.acc || !o.ovld || q.size() != 2 || o.ir !== q[0].ir || o.fld !== q[0].fld || o.err !== q[0].err) begin
        miss++; $display("FAIL bp_hold[%0d] acc=%b v=%b ir=%h fld=%h err=%b qsize=%0d",
                         c, o.acc, o.ovld, o.ir, o.fld, o.err, q.size());
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(o, e);
      if (o.acc) in_valid = 1'b0;
      vecs++; if (!o.dlv || !e.present || o.ir !== e.ir || o.fld !== e.fld || o.err !== e.err) begin
        miss++; $display("FAIL bp_drain[%0d] dlv=%b ir=%h fld=%h err=%b want ir=%h fld=%h err=%b",
                         c, o.dlv, o.ir, o.fld, o.err, e.ir, e.fld, e.err);
      end
    end
    in_valid = 1'b0;
    vecs++; if (q.size() != 0 || out_valid !== 1'b0) begin
      miss++; $display("FAIL bp_empty qsize=%0d out_valid=%b want 0 0", q.size(), out_valid);
    end
  endtask

  task automatic test_random();
    obs_t o; obs_t po; exp_t e;
    logic exp_rdy;
    logic have_prev;
    have_prev = 1'b0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      fsel      = 2'($urandom);
      pc        = 16'($urandom);
      base_ir   = 16'($urandom);
      if ($urandom_range(0, 4) == 0) target = 16'($urandom);
      else if (fsel[1]) target = 16'(int'(pc) + 1 + int'($urandom_range(0, 2200)) - 1100);
      else target = 16'(int'($urandom_range(0, 80)) - 40);
      exp_rdy = (q.size() < 2) || out_ready;
      step(o, e);
      vecs++; if (o.rdy !== exp_rdy) begin miss++; $display("FAIL rand_in_ready[%0d] got %b want %b", c, o.rdy, exp_rdy); end
      if (o.dlv) begin
        vecs++; if (!e.present || o.ir !== e.ir || o.fld !== e.fld || o.err !== e.err) begin
          miss++; $display("FAIL rand_result[%0d] ir=%h fld=%h err=%b want p=%b ir=%h fld=%h err=%b",
                           c, o.ir, o.fld, o.err, e.present, e.ir, e.fld, e.err);
        end
      end
      if (have_prev && po.ovld && !po.ordy) begin
        vecs++; if (!o.ovld || o.ir !== po.ir || o.fld !== po.fld || o.err !== po.err) begin
          miss++; $display("FAIL rand_stall_hold[%0d] v=%b ir=%h fld=%h err=%b want ir=%h fld=%h err=%b",
                           c, o.ovld, o.ir, o.fld, o.err, po.ir, po.fld, po.err);
        end
      end
      vecs++; if (err_count !== 8'(ecnt)) begin miss++; $display("FAIL rand_err_count[%0d] got %0d want %0d", c, err_count, ecnt); end
      po = o; have_prev = 1'b1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(o, e);
      if (o.dlv) begin
        vecs++; if (!e.present || o.ir !== e.ir || o.fld !== e.fld || o.err !== e.err) begin
          miss++; $display("FAIL rand_drain[%0d] ir=%h want %h", c, o.ir, e.ir);
        end
      end
    end
    vecs++; if (q.size() != 0) begin miss++; $display("FAIL rand_leftover got %0d pending want 0", q.size()); end
  endtask

  task automatic test_reset_inflight();
    obs_t o; exp_t e;
    out_ready = 1'b0; in_valid = 1'b1;
    fsel = 2'd0; pc = 16'h0000; base_ir = 16'h1234; target = 16'h0100;
    for (int i = 0; i < 2; i++) begin
      step(o, e);
      vecs++; if (o.acc !== 1'b1) begin miss++; $display("FAIL rst_fill[%0d] got %b want 1", i, o.acc); end
    end
    Reset = 1'b0; out_ready = 1'b1;
    step(o, e);
    Reset = 1'b1; in_valid = 1'b0;
    vecs++; if ({out_valid, in_ready} !== 2'b01) begin
      miss++; $display("FAIL rst_flight_flags out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    vecs++; if (err_count !== 8'd0) begin miss++; $display("FAIL rst_flight_err_count got %0d want 0", err_count); end
    for (int c = 0; c < 3; c++) begin
      step(o, e);
      vecs++; if (o.dlv !== 1'b0) begin miss++; $display("FAIL rst_dropped[%0d] delivered ir=%h want nothing", c, o.ir); end
    end
  endtask

  task automatic test_saturation();
    obs_t o; exp_t e;
    int delivered;
    delivered = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    fsel = 2'd0; pc = 16'h0000; target = 16'h0100;
    for (int c = 0; c < 400 && delivered < 300; c++) begin
      base_ir = 16'($urandom);
      if (q.size() + delivered >= 300) in_valid = 1'b0;
      step(o, e);
      if (o.dlv) begin
        delivered++;
        vecs++; if (!e.present || o.ir !== e.ir || o.fld !== e.fld || o.err !== 1'b1) begin
          miss++; $display("FAIL sat_result[%0d] ir=%h err=%b want ir=%h err=1", c, o.ir, o.err, e.ir);
        end
      end
    end
    in_valid = 1'b0;
    vecs++; if (delivered != 300) begin miss++; $display("FAIL sat_timeout delivered %0d want 300", delivered); end
    vecs++; if (err_count !== 8'd255 || ecnt != 255) begin
      miss++; $display("FAIL sat_err_count got %0d want 255 (model %0d)", err_count, ecnt);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_inflight();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
